// File: rtl/conv_mac_acc.sv
// conv_mac_acc: multiply-accumulate stage for one convolution window.
// Each accepted activation/weight tap is multiplied and summed. After KERNEL_SIZE taps
// the window result moves into a valid/ready output register.
// Optional feature: define CONV_MAC_RELU_EN to clamp negative window results to zero
// as they are written into the output register.
module conv_mac_acc #(
  parameter int DATA_BW     = 8,
  parameter int WEIGHT_BW   = 8,
  parameter int KERNEL_SIZE = 9,
  parameter int ACC_BW      = 20,
  localparam int TAP_BW     = $clog2(KERNEL_SIZE)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_valid,
  input  logic signed [DATA_BW-1:0]   i_x,
  input  logic signed [WEIGHT_BW-1:0] i_w,
  input  logic                        i_clear,
  output logic                        o_ready,
  output logic                        o_valid,
  output logic signed [ACC_BW-1:0]    o_acc,
  input  logic                        i_ready,
  output logic [TAP_BW-1:0]           o_tap
);

  localparam int PROD_BW = DATA_BW + WEIGHT_BW;
  localparam logic [TAP_BW-1:0] LAST_TAP = TAP_BW'(KERNEL_SIZE - 1);

  logic signed [ACC_BW-1:0] acc_q, acc_d;
  logic signed [ACC_BW-1:0] oacc_q, oacc_d;
  logic [TAP_BW-1:0]        tap_q, tap_d;
  logic                     valid_q, valid_d;

  logic signed [PROD_BW-1:0] prod;
  logic signed [ACC_BW-1:0]  prod_ext;
  logic signed [ACC_BW-1:0]  sum;
  logic signed [ACC_BW-1:0]  result;
  logic                      acc_en;

  // Only the final tap has to wait for room in the output register.
  assign o_ready = (tap_q != LAST_TAP) || !valid_q || i_ready;
  assign acc_en  = i_valid && o_ready;

  assign o_valid = valid_q;
  assign o_acc   = oacc_q;
  assign o_tap   = tap_q;

  // Full-precision signed product, sign-extended to accumulator width.
  always_comb begin
    prod     = i_x * i_w;
    prod_ext = {{(ACC_BW - PROD_BW){prod[PROD_BW-1]}}, prod};
    sum      = (tap_q == '0) ? prod_ext : acc_q + prod_ext;
`ifdef CONV_MAC_RELU_EN
    result   = sum[ACC_BW-1] ? '0 : sum;
`else
    result   = sum;
`endif
  end

  // Next state: output handshake first, then clear or tap acceptance.
  always_comb begin
    acc_d   = acc_q;
    tap_d   = tap_q;
    oacc_d  = oacc_q;
    valid_d = valid_q;
    if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
    if (i_clear) begin
      acc_d = '0;
      tap_d = '0;
    end else if (acc_en) begin
      if (tap_q == LAST_TAP) begin
        oacc_d  = result;
        valid_d = 1'b1;
        acc_d   = '0;
        tap_d   = '0;
      end else begin
        acc_d = sum;
        tap_d = tap_q + TAP_BW'(1);
      end
    end
  end

  // State registers with synchronous reset that drops any partial sum or held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      tap_q   <= '0;
      oacc_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      tap_q   <= tap_d;
      oacc_q  <= oacc_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_conv_mac_acc.sv
// Testbench for conv_mac_acc: directed scenarios plus random traffic, all checked
// against an integer window-sum model kept in the bench.
module tb_conv_mac_acc;

  localparam int K     = 9;
  localparam int ACCW  = 20;
  localparam int TAPW  = $clog2(K);
  localparam int VECW  = 1 + ACCW + TAPW + 1;

  logic                   clk = 1'b0;
  logic                   rst, iValid, iClear, iReady;
  logic signed [7:0]      iX, iW;
  logic                   oReady, oValid;
  logic signed [ACCW-1:0] oAcc;
  logic [TAPW-1:0]        oTap;

  int nCmp  = 0;
  int nFail = 0;

  // Reference model: taps seen in the current window, their running integer sum,
  // and the held result.
  int                     mCount;
  longint                 mSum;
  bit                     mValid;
  logic signed [ACCW-1:0] mAcc;

  conv_mac_acc #(.DATA_BW(8), .WEIGHT_BW(8), .KERNEL_SIZE(K), .ACC_BW(ACCW)) dut (
    .clk(clk), .rst(rst), .i_valid(iValid), .i_x(iX), .i_w(iW), .i_clear(iClear),
    .o_ready(oReady), .o_valid(oValid), .o_acc(oAcc), .i_ready(iReady), .o_tap(oTap)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  function automatic bit modelReady();
    return (mCount != K - 1) || !mValid || iReady;
  endfunction

  function automatic logic signed [ACCW-1:0] windowResult(input longint s);
    logic signed [ACCW-1:0] r;
    r = s[ACCW-1:0];
`ifdef CONV_MAC_RELU_EN
    if (r < 0) r = '0;
`endif
    return r;
  endfunction

  function automatic logic [VECW-1:0] expVec();
    return {mValid, mAcc, TAPW'(mCount), modelReady()};
  endfunction

  task automatic stepModel();
    bit accept;
    if (rst) begin
      mCount = 0; mSum = 0; mValid = 0; mAcc = '0;
    end else begin
      accept = iValid && modelReady();
      if (mValid && iReady) mValid = 0;
      if (iClear) begin
        mCount = 0; mSum = 0;
      end else if (accept) begin
        mSum = mSum + longint'(iX) * longint'(iW);
        if (mCount == K - 1) begin
          mValid = 1; mAcc = windowResult(mSum); mSum = 0; mCount = 0;
        end else begin
          mCount++;
        end
      end
    end
  endtask

  task automatic clockCycle();
    stepModel();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic v, input logic signed [7:0] x,
                       input logic signed [7:0] w, input logic c, input logic rd);
    rst = r; iValid = v; iX = x; iW = w; iClear = c; iReady = rd;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 8'($urandom), 8'($urandom), 0, 1);
      clockCycle();
      drive(1, 1, 8'($urandom), 8'($urandom), 0, 1);
      nCmp++;
      if ({oValid, oAcc, oTap, oReady} !== {1'b0, {ACCW{1'b0}}, {TAPW{1'b0}}, 1'b1}) begin
        nFail++;
        $display("[TB] FAIL reset_state got v=%b acc=%0d tap=%0d rdy=%b want 0/0/0/1", oValid, oAcc, oTap, oReady);
      end
    end
    drive(0, 0, 0, 0, 0, 1);
    clockCycle();
  endtask

  task automatic test_basic();
    for (int i = 1; i <= K; i++) begin
      drive(0, 1, 8'(i), 1, 0, 1);
      nCmp++;
      if ({oValid, oAcc, oTap, oReady} !== expVec()) begin
        nFail++; $display("[TB] FAIL basic_tap%0d got %h want %h", i, {oValid, oAcc, oTap, oReady}, expVec());
      end
      clockCycle();
    end
    drive(0, 0, 0, 0, 0, 1);
    nCmp++;
    if (oValid !== 1'b1 || oAcc !== 20'sd45) begin
      nFail++; $display("[TB] FAIL basic_result got v=%b acc=%0d want v=1 acc=45", oValid, oAcc);
    end
    clockCycle();
    drive(0, 0, 0, 0, 0, 1);
    nCmp++;
    if (oValid !== 1'b0) begin
      nFail++; $display("[TB] FAIL basic_one_cycle got v=%b want v=0", oValid);
    end
    clockCycle();
  endtask

  task automatic test_negative();
    logic signed [ACCW-1:0] want;
`ifdef CONV_MAC_RELU_EN
    want = '0;
`else
    want = -20'sd146304;
`endif
    for (int i = 0; i < K; i++) begin
      drive(0, 1, -8'sd128, 8'sd127, 0, 1);
      clockCycle();
    end
    drive(0, 0, 0, 0, 0, 1);
    nCmp++;
    if (oValid !== 1'b1 || oAcc !== want || oAcc !== mAcc) begin
      nFail++; $display("[TB] FAIL negative_result got v=%b acc=%0d want v=1 acc=%0d", oValid, oAcc, want);
    end
    clockCycle();
  endtask

  task automatic test_backpressure();
    for (int i = 1; i <= K; i++) begin
      drive(0, 1, 8'(i), 1, 0, 0);
      clockCycle();
    end
    for (int i = 0; i < K - 1; i++) begin
      drive(0, 1, 2, 3, 0, 0);
      nCmp++;
      if (oReady !== 1'b1 || oAcc !== 20'sd45 || oValid !== 1'b1) begin
        nFail++; $display("[TB] FAIL bp_early_tap%0d got rdy=%b v=%b acc=%0d want 1/1/45", i, oReady, oValid, oAcc);
      end
      clockCycle();
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 2, 3, 0, 0);
      nCmp++;
      if (oReady !== 1'b0 || oAcc !== 20'sd45 || oTap !== TAPW'(K - 1)) begin
        nFail++; $display("[TB] FAIL bp_stall got rdy=%b acc=%0d tap=%0d want 0/45/%0d", oReady, oAcc, oTap, K - 1);
      end
      clockCycle();
    end
    drive(0, 1, 2, 3, 0, 1);
    nCmp++;
    if (oReady !== 1'b1) begin
      nFail++; $display("[TB] FAIL bp_release got rdy=%b want 1", oReady);
    end
    clockCycle();
    drive(0, 0, 0, 0, 0, 1);
    nCmp++;
    if (oValid !== 1'b1 || oAcc !== 20'sd54 || oAcc !== mAcc) begin
      nFail++; $display("[TB] FAIL bp_result got v=%b acc=%0d want v=1 acc=54", oValid, oAcc);
    end
    clockCycle();
  endtask

  task automatic test_clear();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 5, 5, 0, 1);
      clockCycle();
    end
    drive(0, 1, 5, 5, 1, 1);
    nCmp++;
    if (oReady !== 1'b1 || oTap !== 4'd4) begin
      nFail++; $display("[TB] FAIL clear_pre got rdy=%b tap=%0d want 1/4", oReady, oTap);
    end
    clockCycle();
    for (int i = 0; i < K; i++) begin
      drive(0, 1, 1, 2, 0, 1);
      nCmp++;
      if ({oValid, oAcc, oTap, oReady} !== expVec()) begin
        nFail++; $display("[TB] FAIL clear_tap%0d got %h want %h", i, {oValid, oAcc, oTap, oReady}, expVec());
      end
      clockCycle();
    end
    drive(0, 0, 0, 0, 0, 1);
    nCmp++;
    if (oValid !== 1'b1 || oAcc !== 20'sd18) begin
      nFail++; $display("[TB] FAIL clear_result got v=%b acc=%0d want v=1 acc=18", oValid, oAcc);
    end
    clockCycle();
  endtask

  task automatic test_streaming();
    int seen;
    seen = 0;
    for (int i = 0; i < 3 * K; i++) begin
      drive(0, 1, 1, 1, 0, 1);
      nCmp++;
      if (oValid !== ((i == K) || (i == 2 * K)) || {oValid, oAcc, oTap, oReady} !== expVec()) begin
        nFail++; $display("[TB] FAIL stream_cycle%0d got %h want %h", i, {oValid, oAcc, oTap, oReady}, expVec());
      end
      if (oValid === 1'b1) begin
        seen++;
        nCmp++;
        if (oAcc !== 20'sd9) begin
          nFail++; $display("[TB] FAIL stream_value got acc=%0d want 9", oAcc);
        end
      end
      clockCycle();
    end
    drive(0, 0, 0, 0, 0, 1);
    if (oValid === 1'b1) seen++;
    nCmp++;
    if (seen != 3) begin
      nFail++; $display("[TB] FAIL stream_count got %0d results want 3", seen);
    end
    clockCycle();
    for (int i = 0; i < K + 4; i++) begin
      drive(0, 1, 1, 1, 0, 1);
      clockCycle();
    end
    drive(1, 1, 1, 1, 0, 1);
    clockCycle();
    drive(0, 0, 0, 0, 0, 1);
    nCmp++;
    if (oTap !== '0 || oValid !== 1'b0) begin
      nFail++; $display("[TB] FAIL stream_reset got tap=%0d v=%b want 0/0", oTap, oValid);
    end
    for (int i = 0; i < K; i++) begin
      drive(0, 1, 1, 1, 0, 1);
      clockCycle();
    end
    drive(0, 0, 0, 0, 0, 1);
    nCmp++;
    if (oValid !== 1'b1 || oAcc !== 20'sd9) begin
      nFail++; $display("[TB] FAIL stream_after_reset got v=%b acc=%0d want v=1 acc=9", oValid, oAcc);
    end
    clockCycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 75), 8'($urandom), 8'($urandom),
            ($urandom_range(0, 99) < 5), ($urandom_range(0, 99) < 50));
      nCmp++;
      if ({oValid, oAcc, oTap, oReady} !== expVec()) begin
        nFail++; $display("[TB] FAIL random_cycle%0d got %h want %h", i, {oValid, oAcc, oTap, oReady}, expVec());
      end
      clockCycle();
    end
  endtask

  // Main sequence: initial reset, directed scenarios, random traffic, summary.
  initial begin
    mCount = 0; mSum = 0; mValid = 0; mAcc = '0;
    rst = 1; iValid = 0; iX = 0; iW = 0; iClear = 0; iReady = 1;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_negative();
    test_backpressure();
    test_clear();
    test_streaming();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nCmp, nFail);
    $finish;
  end

endmodule
